// File: rtl/return_addr_stack_if.sv
// return_addr_stack_if: decode-side controls and fetch-side redirect outputs of the return-address stack
interface return_addr_stack_if #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 8
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    logic              stall, call, ret, irq_take, rti, ien, iof, err_clr;
    logic [ADDR_W-1:0] call_ret_adr, irq_ret_adr, RTS_adr, RTI_adr;
    logic              irq_ack, ie, in_isr, empty, full, overflow, underflow;
    logic [CNT_W-1:0]  count;
    modport master (
        output stall, call, call_ret_adr, ret, irq_take, irq_ret_adr, rti, ien, iof, err_clr,
        input  RTS_adr, RTI_adr, irq_ack, ie, in_isr, count, empty, full, overflow, underflow
    );
    modport slave (
        input  stall, call, call_ret_adr, ret, irq_take, irq_ret_adr, rti, ien, iof, err_clr,
        output RTS_adr, RTI_adr, irq_ack, ie, in_isr, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/return_addr_stack.sv
// return_addr_stack: circular call stack plus interrupt-return register and interrupt enable/ISR state
module return_addr_stack #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 8
) (
    input logic               clk,
    input logic               rst,
    return_addr_stack_if.slave bus
);
    localparam int PW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PW-1:0]     sp, top;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] rti_adr;
    logic              ie_q, isr_q, ovf_q, unf_q;
    logic              empty, full, push, pop, repl, over, under, ack, rti_ok;
    always_comb begin
        empty  = cnt == '0;
        full   = cnt == CNT_W'(DEPTH);
        top    = sp - PW'(1);
        // call+ret on an empty stack degrades to a plain push
        push   = ~bus.stall & bus.call & (~bus.ret | empty);
        repl   = ~bus.stall & bus.call & bus.ret & ~empty;
        pop    = ~bus.stall & bus.ret & ~bus.call & ~empty;
        under  = ~bus.stall & bus.ret & ~bus.call & empty;
        over   = push & full;
        ack    = bus.irq_take & ie_q & ~isr_q & ~bus.stall;
        rti_ok = ~bus.stall & bus.rti & isr_q & ~ack;
    end
    assign bus.RTS_adr   = empty ? '0 : mem[top];
    assign bus.RTI_adr   = rti_adr;
    assign bus.irq_ack   = ack;
    assign bus.ie        = ie_q;
    assign bus.in_isr    = isr_q;
    assign bus.count     = cnt;
    assign bus.empty     = empty;
    assign bus.full      = full;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            sp  <= '0;
            cnt <= '0;
        end else if (push) begin
            // when full the write lands on the oldest slot, so count saturates
            mem[sp] <= bus.call_ret_adr;
            sp      <= sp + PW'(1);
            cnt     <= full ? cnt : cnt + CNT_W'(1);
        end else if (repl) begin
            mem[top] <= bus.call_ret_adr;
        end else if (pop) begin
            sp  <= top;
            cnt <= cnt - CNT_W'(1);
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= over | (ovf_q & ~bus.err_clr);
            unf_q <= under | (unf_q & ~bus.err_clr);
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rti_adr <= '0;
            ie_q    <= 1'b0;
            isr_q   <= 1'b0;
        end else if (ack) begin
            rti_adr <= bus.irq_ret_adr;
            isr_q   <= 1'b1;
            ie_q    <= 1'b0;
        end else if (rti_ok) begin
            isr_q <= 1'b0;
            ie_q  <= 1'b1;
        end else if (~bus.stall & bus.iof) begin
            ie_q <= 1'b0;
        end else if (~bus.stall & bus.ien) begin
            ie_q <= 1'b1;
        end
    end
endmodule

// File: doc/return_addr_stack.md
# return_addr_stack

Parametrised return-address and interrupt-context unit for the 16-bit RISC core. It sits beside the decode stage and consumes the decoded subroutine-call, subroutine-return, interrupt-enable and RTI controls. It replaces the single fixed return-address input with a DEPTH-entry circular call stack plus a dedicated interrupt-return register. Fetch uses its outputs to redirect the PC on RTS and RTI.

## Interface
- ADDR_W, 12, width of instruction addresses (PC width).
- DEPTH, 8, call-stack entries; power of two, ≥2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived, not overridden).

- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  pipeline stall. When 1, call/ret/irq_take/rti/ien/iof are ignored and state holds.
- call  in  1  subroutine call decoded; push call_ret_adr.
- call_ret_adr  in  ADDR_W  return address to push (PC+1, computed outside).
- ret  in  1  subroutine return decoded; pop.
- irq_take  in  1  interrupt request presented by the controller.
- irq_ret_adr  in  ADDR_W  address to resume at after the ISR.
- rti  in  1  return-from-interrupt decoded.
- ien  in  1  interrupt enable instruction.
- iof  in  1  interrupt disable instruction.
- err_clr  in  1  clears the sticky error flags; honoured even during stall.
- RTS_adr  out  ADDR_W  current top of stack; 0 when empty.
- RTI_adr  out  ADDR_W  saved interrupt return address.
- irq_ack  out  1  interrupt accepted this cycle (combinational).
- ie  out  1  interrupt enable flag.
- in_isr  out  1  ISR in progress.
- count  out  CNT_W  valid entries, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky: a push occurred while full.
- underflow  out  1  sticky: a pop occurred while empty.

## Operation
- Storage: DEPTH×ADDR_W array with write pointer sp (log2 DEPTH bits), modulo-DEPTH wrap. Top entry = mem[sp-1].
- Call stack actions are evaluated only when stall=0.
- Push (call=1, ret=0): mem[sp]<=call_ret_adr; sp<=sp+1.
  - If not full: count+1.
  - If full: the oldest entry is overwritten, count stays DEPTH, overflow<=1.
- Pop (ret=1, call=0):
  - If not empty: sp<=sp-1, count-1.
  - If empty: no state change except underflow<=1.
- Call and ret in the same cycle:
  - If not empty: the top entry is replaced with call_ret_adr; sp and count are unchanged.
  - If empty: plain push; no underflow.
- irq_ack = irq_take & ie & ~in_isr & ~stall.
  - On irq_ack: RTI_adr<=irq_ret_adr, in_isr<=1, ie<=0.
  - irq_take with irq_ack=0 is ignored; the controller keeps it asserted.
- rti with in_isr=1 and no irq_ack: in_isr<=0, ie<=1. rti with in_isr=0 is ignored.
- ie update when no irq_ack and no valid rti: iof=1 → ie<=0; else ien=1 → ie<=1. iof beats ien.
- Priority on ie: irq_ack > rti > iof > ien.
- Call-stack and interrupt actions are independent and may occur in the same cycle.
- err_clr=1: overflow<=0, underflow<=0. A new error in the same cycle sets its flag (set wins).

## Timing
- Reset, asynchronous, takes effect immediately:
  - sp=0, count=0, all mem entries=0.
  - RTS_adr=0, RTI_adr=0, ie=0, in_isr=0, overflow=0, underflow=0.
  - empty=1, full=0, irq_ack=0 (once rst asserted).
- RTS_adr, count, empty, full are combinational from registered state. After a push in cycle N, the new top appears in cycle N+1.
- A ret in cycle N uses the RTS_adr value present in cycle N (pre-pop) for the fetch redirect; the popped state is visible in N+1.
- RTI_adr is valid from the cycle after irq_ack. An rti in cycle N reads RTI_adr in cycle N.
- irq_ack is combinational, with zero-cycle latency from irq_take.
- Stall held for k cycles freezes all outputs for k cycles. Inputs presented during stall are lost; the upstream pipeline holds them.
- rst asserted mid-sequence discards all entries; there is no partial-push state.

## Test plan
- Reset, DEPTH=4, ADDR_W=12: assert rst with call=1 → count=0, empty=1, RTS_adr=0, ie=0, all flags 0.
- Push 0x014, 0x020, 0x033 → count=3, RTS_adr=0x033. Pop twice → RTS_adr=0x014, count=1. Pop → empty=1, RTS_adr=0.
- Push 5 values 0x001..0x005 with DEPTH=4 → full=1, overflow=1, RTS_adr=0x005. Four pops return 0x005,0x004,0x003,0x002. A fifth pop → underflow=1, count=0. Then err_clr → both flags 0.
- Simultaneous call=1/ret=1 with top 0x014, count=2, call_ret_adr=0x0AA → RTS_adr=0x0AA, count=2. The same on an empty stack → count=1, underflow=0.
- Interrupts:
  - ien → ie=1.
  - irq_take with irq_ret_adr=0x015 → irq_ack=1; next cycle RTI_adr=0x015, in_isr=1, ie=0.
  - A second irq_take → irq_ack=0.
  - rti → in_isr=0, ie=1.
  - ien=1 and iof=1 together → ie=0.
- With stall=1 for 3 cycles, pulse call/ret/irq_take/rti → count, RTS_adr, ie, in_isr unchanged and irq_ack=0. err_clr during the stall still clears the flags.
